// File: rtl/multiplier_pkg.sv
// Shared constants and helpers for the array multiplier.
package multiplier_pkg;

  // Operand widths the array is meant to be built for.
  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 8;

  // Full-precision product width for a given operand width.
  function automatic int unsigned product_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: the only arithmetic cell of the multiplier array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a single registered output stage.
//
// Row 0 is the plain partial-product row A & B[0]. Each following row r adds
// partial-product row A & B[r] to the upper bits of the previous row using a
// ripple-carry chain of full adders. The low bit of each row drops out as a
// finished product bit; the last row supplies the upper half of the product.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid
);

  localparam int unsigned PW = product_width(WIDTH);

  // pp[i][j] = A[j] & B[i]
  logic [WIDTH-1:0] pp        [WIDTH];
  // Second addend of each adder row (shifted previous row plus its carry-out).
  logic [WIDTH-1:0] row_b     [1:WIDTH-1];
  logic [WIDTH-1:0] row_sum   [1:WIDTH-1];
  // row_carry[r][0] is the row's carry-in, row_carry[r][WIDTH] its carry-out.
  logic [WIDTH:0]   row_carry [1:WIDTH-1];
  logic [PW-1:0]    product_comb;

  // Partial-product AND plane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_bit
      assign pp[i][j] = A[j] & B[i];
    end
  end

  // Adder rows.
  for (genvar r = 1; r < WIDTH; r++) begin : g_row
    // Bit 0 of every row is a half-adder position: full adder with cin tied low.
    assign row_carry[r][0] = 1'b0;

    if (r == 1) begin : g_first
      // Nothing to carry into the top bit yet, so it sees a constant zero.
      assign row_b[r] = {1'b0, pp[0][WIDTH-1:1]};
    end else begin : g_next
      assign row_b[r] = {row_carry[r-1][WIDTH], row_sum[r-1][WIDTH-1:1]};
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      full_adder u_fa (
        .a    (pp[r][j]),
        .b    (row_b[r][j]),
        .cin  (row_carry[r][j]),
        .sum  (row_sum[r][j]),
        .cout (row_carry[r][j+1])
      );
    end

    assign product_comb[r] = row_sum[r][0];
  end

  assign product_comb[0]        = pp[0][0];
  assign product_comb[PW-1:WIDTH] = {row_carry[WIDTH-1][WIDTH], row_sum[WIDTH-1][WIDTH-1:1]};

  // Output register: capture the array result on accepted operands, hold otherwise.
  // NOTE: non-blocking assignments so both registers update from pre-edge values;
  // operands seen while in_valid is low never reach product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= product_comb;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the array multiplier: a WIDTH=2 instance for directed and
// exhaustive cases, and a WIDTH=4 instance for randomized traffic.
module tb_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a2, b2;
  logic       v2;
  logic [3:0] prod2;
  logic       ov2;
  logic [3:0] a4, b4;
  logic       v4;
  logic [7:0] prod4;
  logic       ov4;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected products in issue order, plus the last one delivered (hold value).
  int q2[$];
  int q4[$];
  int last2 = 0;
  int last4 = 0;

  always #5 clk = ~clk;

  multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .in_valid(v2),
    .product(prod2), .out_valid(ov2)
  );

  multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(v4),
    .product(prod4), .out_valid(ov4)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of operands on the WIDTH=2 instance; the model is plain A*B.
  task automatic cycle2(input int a, input int b, input bit v);
    @(posedge clk);
    #1;
    a2 = a[1:0];
    b2 = b[1:0];
    v2 = v;
    if (v && rst_n) q2.push_back(a * b);
  endtask

  task automatic cycle4(input int a, input int b, input bit v);
    @(posedge clk);
    #1;
    a4 = a[3:0];
    b4 = b[3:0];
    v4 = v;
    if (v && rst_n) q4.push_back(a * b);
  endtask

  // Monitor for WIDTH=2 instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
      last2 = 0;
      check("reset product2", int'(prod2), 0);
      check("reset out_valid2", int'(ov2), 0);
    end else if (ov2) begin
      if (q2.size() == 0) begin
        check("spurious out_valid2", int'(ov2), 0);
      end else begin
        last2 = q2.pop_front();
        check("product2", int'(prod2), last2);
      end
    end else begin
      check("hold product2", int'(prod2), last2);
    end
  end

  // Monitor for WIDTH=4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      last4 = 0;
      check("reset product4", int'(prod4), 0);
      check("reset out_valid4", int'(ov4), 0);
    end else if (ov4) begin
      if (q4.size() == 0) begin
        check("spurious out_valid4", int'(ov4), 0);
      end else begin
        last4 = q4.pop_front();
        check("product4", int'(prod4), last4);
      end
    end else begin
      check("hold product4", int'(prod4), last4);
    end
  end

  // Stimulus.
  initial begin
    rst_n = 1'b0;
    a2 = 2'd3; b2 = 2'd3; v2 = 1'b1;
    a4 = 4'd15; b4 = 4'd15; v4 = 1'b1;

    // Reset held for three cycles with live operands; monitors expect zeros.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v2 = 1'b0;
    v4 = 1'b0;

    // Exhaustive WIDTH=2, A outer, B inner.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        cycle2(a, b, 1'b1);
      end
    end

    // Hold: one valid 2*3, then idle with different operands.
    cycle2(2, 3, 1'b1);
    repeat (3) cycle2(1, 1, 1'b0);

    // Mid-run reset between edges, then a fresh operand pair after release.
    cycle2(3, 2, 1'b1);
    cycle2(3, 2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset product2", int'(prod2), 0);
    check("async reset out_valid2", int'(ov2), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a2 = 2'd1; b2 = 2'd3; v2 = 1'b1;
    q2.push_back(3);
    repeat (3) cycle2(0, 0, 1'b0);

    // Randomized WIDTH=4 traffic with corner pairs up front.
    for (int i = 0; i < 1000; i++) begin
      int a, b;
      bit v;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      v = ($urandom_range(0, 3) != 0);
      if (i == 0) begin a = 15; b = 15; v = 1'b1; end
      if (i == 1) begin a = 0;  b = 13; v = 1'b1; end
      if (i == 2) begin a = 11; b = 0;  v = 1'b1; end
      cycle4(a, b, v);
    end
    repeat (3) cycle4(0, 0, 1'b0);

    // Everything issued must have come back.
    check("drain queue2", q2.size(), 0);
    check("drain queue4", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter: WIDTH, default 2, operand width in bits; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: A  input  WIDTH  unsigned multiplicand.
REQ-005 Port: B  input  WIDTH  unsigned multiplier.
REQ-006 Port: in_valid  input  1  A/B are sampled when high at a rising clk edge.
REQ-007 Port: product  output  2*WIDTH  registered unsigned product A*B.
REQ-008 Port: out_valid  output  1  high for one cycle when product holds a new result.
REQ-009 The block SHALL have exactly one clock (clk) and one reset (rst_n); rst_n SHALL be asynchronous and active-low.

Function
REQ-010 The block SHALL compute product = A * B, unsigned, full precision (2*WIDTH bits, no truncation, no overflow possible).
REQ-011 The datapath SHALL be an array multiplier: partial products pp[i][j] = A[j] & B[i], summed by rows of full_adder cells with ripple carry.
REQ-012 For WIDTH=2: product[0]=A0&B0; product[1]=(A1&B0)^(A0&B1); product[2], product[3] = sum and carry of A1&B1 plus the carry from bit 1.
REQ-013 Latency SHALL be exactly one clock: operands sampled at edge N appear on product at edge N with out_valid=1 after that edge (visible in cycle N+1).
REQ-014 When in_valid=0 at an edge, product SHALL hold its previous value and out_valid SHALL be 0 for the next cycle.
REQ-015 Back-to-back in_valid=1 SHALL be accepted every cycle (throughput 1/cycle); no backpressure input exists.
REQ-016 The combinational array SHALL settle within one clk period; no internal pipeline stages.
REQ-017 Boundary: 0*X and X*0 SHALL give 0; max*max (3*3 at WIDTH=2) SHALL give 9 (4'b1001).
REQ-018 X/Z on A or B while in_valid=0 SHALL NOT propagate to product.

Reset
REQ-019 While rst_n=0, product SHALL be 0 and out_valid SHALL be 0, asynchronously, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard any sampled operand; the first out_valid after release SHALL correspond to the first in_valid=1 edge after release.
REQ-021 Reset deassertion SHALL take effect at the next rising clk edge; no other state exists to reset.

Structure
REQ-022 No shared package is required; WIDTH is a module parameter and 2*WIDTH a localparam.
REQ-023 One sub-module, full_adder (inputs a, b, cin; outputs sum, cout), SHALL be instantiated via generate loops to build the array; half-adder positions SHALL use full_adder with cin tied to 0.
REQ-024 The output register (product, out_valid) SHALL be the only sequential logic, in one always block with async reset.

Verification
REQ-025 Reset: hold rst_n=0 for 3 cycles with A=3, B=3, in_valid=1 -> product=0, out_valid=0 throughout.
REQ-026 Exhaustive WIDTH=2: apply all 16 (A,B) pairs with in_valid=1, one per cycle, in order A=0..3 outer, B=0..3 inner -> product equals A*B one cycle later, out_valid=1 each cycle (e.g., 2*3 -> 6, 3*3 -> 9).
REQ-027 Hold: A=2, B=3, in_valid=1 for one cycle, then in_valid=0 with A=1, B=1 -> product stays 6, out_valid pulses once.
REQ-028 Mid-run reset: stream A=3, B=2; assert rst_n=0 between edges -> product drops to 0 immediately; after release, next valid A=1, B=3 -> product=3.
REQ-029 WIDTH=4 randomized: 1000 random A, B -> product matches the A*B reference model, including 15*15=225.
